// File: rtl/axis_pkg.sv
// Shared types for the fsic AXI-Stream receive path: beat widths, the buffered
// entry layout and the ingress frame states.
package axis_pkg;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_STRB_W = 4;
  localparam int AXIS_ID_W   = 2;
  localparam int AXIS_USER_W = 2;

  // One buffered beat; sof is derived on ingress from the frame FSM.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] tdata;
    logic [AXIS_STRB_W-1:0] tstrb;
    logic [AXIS_STRB_W-1:0] tkeep;
    logic                   tlast;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_USER_W-1:0] tuser;
    logic                   sof;
  } axis_beat_t;

  localparam int AXIS_BEAT_W = $bits(axis_beat_t);

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_FRAME = 1'b1
  } axis_rx_state_e;

endpackage

// File: rtl/axis_slave_if.sv
// Upstream AXI-Stream and backend valid/ready signals of the receive slave.
// The slave modport is the DUT view; master is the driving side.
interface axis_slave_if;
  import axis_pkg::*;

  logic                   axis_tvalid;
  logic [AXIS_DATA_W-1:0] axis_tdata;
  logic [AXIS_STRB_W-1:0] axis_tstrb;
  logic [AXIS_STRB_W-1:0] axis_tkeep;
  logic                   axis_tlast;
  logic [AXIS_ID_W-1:0]   axis_tid;
  logic [AXIS_USER_W-1:0] axis_tuser;
  logic                   axis_tready;

  logic                   bk_valid;
  logic [AXIS_DATA_W-1:0] bk_data;
  logic [AXIS_STRB_W-1:0] bk_tstrb;
  logic [AXIS_STRB_W-1:0] bk_tkeep;
  logic [AXIS_ID_W-1:0]   bk_tid;
  logic [AXIS_USER_W-1:0] bk_user;
  logic                   bk_last;
  logic                   bk_sof;
  logic                   bk_ready;
  logic                   bk_done;
  logic                   bk_stall;
  logic                   bk_tid_err;

  modport slave (
    input  axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast,
           axis_tid, axis_tuser, bk_ready,
    output axis_tready, bk_valid, bk_data, bk_tstrb, bk_tkeep, bk_tid,
           bk_user, bk_last, bk_sof, bk_done, bk_stall, bk_tid_err
  );

  modport master (
    output axis_tvalid, axis_tdata, axis_tstrb, axis_tkeep, axis_tlast,
           axis_tid, axis_tuser, bk_ready,
    input  axis_tready, bk_valid, bk_data, bk_tstrb, bk_tkeep, bk_tid,
           bk_user, bk_last, bk_sof, bk_done, bk_stall, bk_tid_err
  );

endinterface

// File: rtl/axis_rx_fifo.sv
// Synchronous first-word-fall-through FIFO: the head entry is always visible on
// rd_data; full/empty come straight from the registered occupancy counter.
module axis_rx_fifo #(
  parameter type beat_t     = logic [45:0],
  parameter int  FIFO_DEPTH = 8,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  beat_t            wr_data,
  input  logic             rd_en,
  output beat_t            rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  beat_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // A write into a full FIFO is dropped even when a read frees a slot this cycle.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // NOTE: storage carries no reset; validity is tracked by count alone, so the
  // array can map onto plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/axis_slave.sv
// fsic AXI-Stream receive slave: buffers upstream beats, marks frame starts,
// checks tid consistency within a frame and flags a stalled backend.
module axis_slave
  import axis_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] RDY_TIMEOUT = 8'd5
) (
  input logic         axi_aclk,
  input logic         axi_areset,
  axis_slave_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  axis_rx_state_e   state;
  axis_rx_state_e   state_nxt;
  axis_beat_t       wr_beat;
  axis_beat_t       head;
  axis_beat_t       shown;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             wr_fire;
  logic             rd_fire;
  logic             beat_sof;
  logic             tid_mismatch;
  logic [AXIS_ID_W-1:0] frame_tid;
  logic             tid_err;
  logic [7:0]       stall_cnt;

  // Handshakes depend only on registered occupancy and reset, never on bk_ready.
  assign bus.axis_tready = !fifo_full && !axi_areset;
  assign bus.bk_valid    = !fifo_empty && !axi_areset;
  assign wr_fire         = bus.axis_tvalid && bus.axis_tready;
  assign rd_fire         = bus.bk_valid && bus.bk_ready;

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    beat_sof     = 1'b0;
    tid_mismatch = 1'b0;
    case (state)
      RX_IDLE: begin
        beat_sof = 1'b1;
        if (wr_fire && !bus.axis_tlast) begin
          state_nxt = RX_FRAME;
        end
      end
      RX_FRAME: begin
        if (wr_fire) begin
          tid_mismatch = (bus.axis_tid != frame_tid);
          if (bus.axis_tlast) begin
            state_nxt = RX_IDLE;
          end
        end
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // The frame's tid is taken from its first beat; the error flag is sticky.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      frame_tid <= '0;
      tid_err   <= 1'b0;
    end else begin
      if (wr_fire && (state == RX_IDLE)) begin
        frame_tid <= bus.axis_tid;
      end
      if (tid_mismatch) begin
        tid_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      stall_cnt <= '0;
    end else if (bus.bk_valid && !bus.bk_ready) begin
      if (stall_cnt != 8'hFF) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
    end else begin
      stall_cnt <= '0;
    end
  end

  always_comb begin
    wr_beat       = '0;
    wr_beat.tdata = bus.axis_tdata;
    wr_beat.tstrb = bus.axis_tstrb;
    wr_beat.tkeep = bus.axis_tkeep;
    wr_beat.tlast = bus.axis_tlast;
    wr_beat.tid   = bus.axis_tid;
    wr_beat.tuser = bus.axis_tuser;
    wr_beat.sof   = beat_sof;
  end

  axis_rx_fifo #(
    .beat_t     (axis_beat_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (axi_aclk),
    .rst     (axi_areset),
    .wr_en   (wr_fire),
    .wr_data (wr_beat),
    .rd_en   (rd_fire),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Backend data reads as zero whenever no head entry is presented.
  assign shown = bus.bk_valid ? head : '0;

  assign bus.bk_data    = shown.tdata;
  assign bus.bk_tstrb   = shown.tstrb;
  assign bus.bk_tkeep   = shown.tkeep;
  assign bus.bk_tid     = shown.tid;
  assign bus.bk_user    = shown.tuser;
  assign bus.bk_last    = shown.tlast;
  assign bus.bk_sof     = shown.sof;
  assign bus.bk_done    = rd_fire && head.tlast;
  assign bus.bk_stall   = (stall_cnt >= RDY_TIMEOUT);
  assign bus.bk_tid_err = tid_err;

  a_count_bound : assert property (@(posedge axi_aclk) disable iff (axi_areset)
    fifo_count <= CNT_W'(FIFO_DEPTH));

endmodule

// File: tb/tb_axis_slave.sv
// Scoreboard bench for axis_slave: accepted beats are queued with their expected
// sof, and every backend read is compared against the queue head.
module tb_axis_slave;
  import axis_pkg::*;

  logic axi_aclk = 1'b0;
  logic axi_areset;

  always #5 axi_aclk = ~axi_aclk;

  axis_slave_if bus ();

  axis_slave #(
    .FIFO_DEPTH  (8),
    .RDY_TIMEOUT (8'd5)
  ) dut (
    .axi_aclk   (axi_aclk),
    .axi_areset (axi_areset),
    .bus        (bus)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  axis_beat_t sb [$];
  axis_beat_t exp_beat;
  axis_beat_t in_beat;
  logic       in_frame = 1'b0;
  int         done_cnt = 0;
  int         pop_cnt  = 0;
  logic       wrap_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor/scoreboard: sample mid-cycle, pop on backend read, push on upstream accept.
  always @(negedge axi_aclk) begin
    if (axi_areset) begin
      sb.delete();
      in_frame = 1'b0;
    end else begin
      if (bus.bk_valid && bus.bk_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          exp_beat = sb.pop_front();
          pop_cnt++;
          check("bk_data", 64'(bus.bk_data), 64'(exp_beat.tdata));
          check("bk_tstrb", 64'(bus.bk_tstrb), 64'(exp_beat.tstrb));
          check("bk_tkeep", 64'(bus.bk_tkeep), 64'(exp_beat.tkeep));
          check("bk_tid", 64'(bus.bk_tid), 64'(exp_beat.tid));
          check("bk_user", 64'(bus.bk_user), 64'(exp_beat.tuser));
          check("bk_last", 64'(bus.bk_last), 64'(exp_beat.tlast));
          check("bk_sof", 64'(bus.bk_sof), 64'(exp_beat.sof));
          check("bk_done", 64'(bus.bk_done), 64'(exp_beat.tlast));
        end
      end else begin
        check("done_idle", 64'(bus.bk_done), 64'd0);
      end
      if (!bus.bk_valid) begin
        check("data_idle_zero", 64'(bus.bk_data), 64'd0);
      end
      if (bus.bk_done) done_cnt++;
      if (bus.axis_tvalid && bus.axis_tready) begin
        in_beat.tdata = bus.axis_tdata;
        in_beat.tstrb = bus.axis_tstrb;
        in_beat.tkeep = bus.axis_tkeep;
        in_beat.tlast = bus.axis_tlast;
        in_beat.tid   = bus.axis_tid;
        in_beat.tuser = bus.axis_tuser;
        in_beat.sof   = !in_frame;
        sb.push_back(in_beat);
        in_frame = !bus.axis_tlast;
      end
    end
  end

  task automatic drive_beat(input logic [31:0] d, input logic last, input logic [1:0] id);
    bus.axis_tvalid = 1'b1;
    bus.axis_tdata  = d;
    bus.axis_tstrb  = d[3:0];
    bus.axis_tkeep  = ~d[3:0];
    bus.axis_tlast  = last;
    bus.axis_tid    = id;
    bus.axis_tuser  = d[5:4];
  endtask

  // Returns at posedge+1 of the accepting edge; waits counts refused cycles.
  task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] id,
                           output int waits);
    logic acc;
    drive_beat(d, last, id);
    waits = 0;
    do begin
      acc = bus.axis_tready;
      @(posedge axi_aclk);
      #1;
      if (!acc) waits++;
    end while (!acc && waits < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle();
    bus.axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge axi_aclk);
      n++;
    end
    check("drain_sb", 64'(sb.size()), 64'd0);
    @(posedge axi_aclk);
    #1;
    check("drain_empty", 64'(bus.bk_valid), 64'd0);
  endtask

  initial begin
    int w;
    int total_w;
    int idx;
    int d0;
    int p0;
    logic acc;

    axi_areset      = 1'b1;
    bus.bk_ready    = 1'b0;
    bus.axis_tvalid = 1'b0;
    drive_beat(32'd0, 1'b0, 2'd0);
    bus.axis_tvalid = 1'b0;
    wrap_done       = 1'b0;

    // Reset values
    repeat (3) @(posedge axi_aclk);
    #1;
    check("rst_tready", 64'(bus.axis_tready), 64'd0);
    check("rst_valid", 64'(bus.bk_valid), 64'd0);
    check("rst_data", 64'(bus.bk_data), 64'd0);
    check("rst_stall", 64'(bus.bk_stall), 64'd0);
    check("rst_tid_err", 64'(bus.bk_tid_err), 64'd0);
    axi_areset = 1'b0;
    @(posedge axi_aclk);
    #1;
    check("tready_after_rst", 64'(bus.axis_tready), 64'd1);

    // Single-beat frame
    bus.bk_ready = 1'b1;
    d0 = done_cnt;
    send_beat(32'hA5A5_0001, 1'b1, 2'd0, w);
    check("single_latency", 64'(bus.bk_valid), 64'd1);
    check("single_sof", 64'(bus.bk_sof), 64'd1);
    check("single_last", 64'(bus.bk_last), 64'd1);
    idle();
    wait_drain();
    check("single_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Back-to-back 4-beat frame
    total_w = 0;
    for (int i = 1; i <= 4; i++) begin
      send_beat(32'(i), (i == 4), 2'd2, w);
      total_w += w;
      check("b2b_valid", 64'(bus.bk_valid), 64'd1);
      check("b2b_head", 64'(bus.bk_data), 64'(i));
    end
    idle();
    check("b2b_tready_waits", 64'(total_w), 64'd0);
    @(negedge axi_aclk);
    #1;
    check("b2b_throughput", 64'(sb.size()), 64'd0);
    wait_drain();

    // Fill with the backend stalled
    bus.bk_ready = 1'b0;
    idx = 1;
    for (int j = 1; j <= 12; j++) begin
      drive_beat(32'(idx), (idx == 10), 2'd0);
      acc = bus.axis_tready;
      @(posedge axi_aclk);
      #1;
      if (acc) idx++;
      check("fill_tready", 64'(bus.axis_tready), 64'(j < 8));
      check("fill_stall", 64'(bus.bk_stall), 64'(j >= 6));
    end
    check("fill_accepted", 64'(idx - 1), 64'd8);
    bus.bk_ready = 1'b1;
    @(posedge axi_aclk);
    #1;
    check("stall_fall", 64'(bus.bk_stall), 64'd0);
    check("tready_reassert", 64'(bus.axis_tready), 64'd1);
    for (; idx <= 10; idx++) begin
      send_beat(32'(idx), (idx == 10), 2'd0, w);
    end
    idle();
    wait_drain();

    // Wrap-around with random backend readiness
    p0 = pop_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_beat(32'(1000 + i), ($urandom_range(0, 3) == 0) || (i == 39), 2'd1, w);
        end
        idle();
        wrap_done = 1'b1;
      end
      begin
        while (!wrap_done) begin
          bus.bk_ready = 1'($urandom_range(0, 1));
          @(posedge axi_aclk);
          #1;
        end
      end
    join
    bus.bk_ready = 1'b1;
    wait_drain();
    check("wrap_count", 64'(pop_cnt - p0), 64'd40);

    // Tid consistency
    check("tid_err_clean", 64'(bus.bk_tid_err), 64'd0);
    send_beat(32'h0000_0051, 1'b0, 2'd1, w);
    check("tid_err_b1", 64'(bus.bk_tid_err), 64'd0);
    send_beat(32'h0000_0052, 1'b0, 2'd1, w);
    check("tid_err_b2", 64'(bus.bk_tid_err), 64'd0);
    send_beat(32'h0000_0053, 1'b1, 2'd3, w);
    check("tid_err_b3", 64'(bus.bk_tid_err), 64'd1);
    send_beat(32'h0000_0054, 1'b1, 2'd2, w);
    check("tid_err_sticky", 64'(bus.bk_tid_err), 64'd1);
    idle();
    wait_drain();
    axi_areset = 1'b1;
    @(posedge axi_aclk);
    #1;
    check("tid_err_rst", 64'(bus.bk_tid_err), 64'd0);
    axi_areset = 1'b0;
    @(posedge axi_aclk);
    #1;

    // Reset mid-frame
    bus.bk_ready = 1'b0;
    send_beat(32'h0000_0200, 1'b0, 2'd0, w);
    send_beat(32'h0000_0201, 1'b0, 2'd0, w);
    idle();
    check("mid_valid_before", 64'(bus.bk_valid), 64'd1);
    axi_areset = 1'b1;
    @(posedge axi_aclk);
    #1;
    check("mid_rst_valid", 64'(bus.bk_valid), 64'd0);
    check("mid_rst_tready", 64'(bus.axis_tready), 64'd0);
    check("mid_rst_data", 64'(bus.bk_data), 64'd0);
    axi_areset = 1'b0;
    @(posedge axi_aclk);
    #1;
    check("mid_post_empty", 64'(bus.bk_valid), 64'd0);
    check("mid_post_tready", 64'(bus.axis_tready), 64'd1);
    bus.bk_ready = 1'b1;
    send_beat(32'h0000_0300, 1'b1, 2'd2, w);
    check("mid_post_sof", 64'(bus.bk_sof), 64'd1);
    check("mid_post_data", 64'(bus.bk_data), 64'h300);
    idle();
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
